// File: rtl/and_unit_arbiter.sv
// rtl/and_unit_arbiter.sv - round-robin arbiter sharing one registered AND unit
module and_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*WIDTH-1:0] i_a,
  input  logic [N_REQ*WIDTH-1:0] i_b,
  output logic [N_REQ-1:0]       o_gnt,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_result,
  output logic [ID_W-1:0]        o_id,
  input  logic                   i_rdy,
  output logic                   o_busy,
  output logic [15:0]            o_ops
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic [ID_W-1:0]  id, last_id, winner;
  logic             found, arb_en, take;

  // Search begins just after the last winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && i_req[(int'(last_id) + k) % N_REQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(last_id) + k) % N_REQ);
      end
    end
  end

  assign arb_en = (state == IDLE) || ((state == RESP) && i_rdy);
  assign take   = arb_en && found;
  assign o_busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (i_rdy) state_nxt = found ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_gnt    <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_id     <= '0;
      o_ops    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      id       <= '0;
      last_id  <= ID_W'(N_REQ - 1);
    end else begin
      o_gnt <= '0;
      if (take) begin
        o_gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
        op_a    <= i_a[int'(winner)*WIDTH +: WIDTH];
        op_b    <= i_b[int'(winner)*WIDTH +: WIDTH];
        id      <= winner;
        last_id <= winner;
      end
      if (state == CALC) begin
        o_result <= op_a & op_b;
        o_id     <= id;
        o_valid  <= 1'b1;
      end
      if ((state == RESP) && i_rdy) begin
        o_valid <= 1'b0;
        if (o_ops != 16'hFFFF) o_ops <= o_ops + 16'd1;
      end
    end
  end

endmodule
